// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bus: datapath status in, stage-register control and perf counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  logic [31:0]          inst_d;
  logic [31:0]          inst_x;
  logic                 redirect_x;
  logic                 mem_busy;
  logic                 retire_w;
  logic                 cnt_clr;
  logic                 stall_f;
  logic                 stall_d;
  logic                 bubble_x;
  logic                 flush_d;
  logic                 freeze;
  logic [CNT_WIDTH-1:0] cycle_cnt;
  logic [CNT_WIDTH-1:0] inst_cnt;
  logic [CNT_WIDTH-1:0] stall_cnt;

  // Datapath side
  modport master (
    output inst_d, inst_x, redirect_x, mem_busy, retire_w, cnt_clr,
    input  stall_f, stall_d, bubble_x, flush_d, freeze,
    input  cycle_cnt, inst_cnt, stall_cnt
  );

  // Hazard controller side
  modport slave (
    input  inst_d, inst_x, redirect_x, mem_busy, retire_w, cnt_clr,
    output stall_f, stall_d, bubble_x, flush_d, freeze,
    output cycle_cnt, inst_cnt, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 3-stage core: load-use stalls, post-redirect
// squash of D, whole-pipe freeze on memory busy, and MMIO perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int unsigned FL_W = $clog2(FLUSH_CYCLES + 1);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_FLUSH    = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_t;

  state_t              state, state_n;
  state_t              ret_state, ret_state_n;
  state_t              eff_state;
  logic [FL_W-1:0]     flush_left, flush_left_n;

  logic [6:0]          opcode_d, opcode_x;
  logic [4:0]          rs1_d, rs2_d, rd_x;
  logic                reads_rs1, reads_rs2, load_use;

  logic                stall_c, bubble_c, flush_c, freeze_c;
  logic                stall_g, bubble_g, flush_g, freeze_g;

  logic [CNT_WIDTH-1:0] cycle_q, inst_q, stall_q;

  // Fields outside the decode are intentionally ignored
  logic unused_inst_bits;
  assign unused_inst_bits = ^{bus.inst_d[31:25], bus.inst_d[14:7], bus.inst_x[31:12]};

  assign opcode_d = bus.inst_d[6:0];
  assign rs1_d    = bus.inst_d[19:15];
  assign rs2_d    = bus.inst_d[24:20];
  assign opcode_x = bus.inst_x[6:0];
  assign rd_x     = bus.inst_x[11:7];

  // Which source registers the instruction in D actually reads, and load-use detect
  always_comb begin
    reads_rs1 = !((opcode_d == OP_LUI) || (opcode_d == OP_AUIPC) || (opcode_d == OP_JAL));
    reads_rs2 = (opcode_d == OP_OP) || (opcode_d == OP_STORE) || (opcode_d == OP_BRANCH);
    load_use  = (opcode_x == OP_LOAD) && (rd_x != 5'd0) &&
                ((reads_rs1 && (rs1_d == rd_x)) || (reads_rs2 && (rs2_d == rd_x)));
  end

  // State register: current state, post-freeze return state, squash countdown
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RUN;
      ret_state  <= S_RUN;
      flush_left <= '0;
    end else begin
      state      <= state_n;
      ret_state  <= ret_state_n;
      flush_left <= flush_left_n;
    end
  end

  // Next state and hazard outputs; MEM_WAIT with busy low behaves as its return state
  always_comb begin
    state_n      = state;
    ret_state_n  = ret_state;
    flush_left_n = flush_left;
    stall_c      = 1'b0;
    bubble_c     = 1'b0;
    flush_c      = 1'b0;
    freeze_c     = 1'b0;
    eff_state    = (state == S_MEM_WAIT) ? ret_state : state;

    if (bus.mem_busy) begin
      freeze_c    = 1'b1;
      state_n     = S_MEM_WAIT;
      ret_state_n = eff_state;
    end else begin
      ret_state_n = S_RUN;
      case (eff_state)
        S_FLUSH: begin
          flush_c = 1'b1;
          if (flush_left <= FL_W'(1)) begin
            state_n      = S_RUN;
            flush_left_n = '0;
          end else begin
            state_n      = S_FLUSH;
            flush_left_n = flush_left - FL_W'(1);
          end
        end
        default: begin
          state_n = S_RUN;
          if (bus.redirect_x) begin
            flush_c = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_n      = S_FLUSH;
              flush_left_n = FL_W'(FLUSH_CYCLES - 1);
            end
          end else if (load_use) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
          end
        end
      endcase
    end
  end

  // Outputs are forced quiet while reset is held
  assign stall_g  = stall_c  & ~rst;
  assign bubble_g = bubble_c & ~rst;
  assign flush_g  = flush_c  & ~rst;
  assign freeze_g = freeze_c & ~rst;

  assign bus.stall_f  = stall_g;
  assign bus.stall_d  = stall_g;
  assign bus.bubble_x = bubble_g;
  assign bus.flush_d  = flush_g;
  assign bus.freeze   = freeze_g;

  // Performance counters; clear beats increment, all wrap naturally
  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) begin
      cycle_q <= '0;
      inst_q  <= '0;
      stall_q <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_WIDTH'(1);
      if (bus.retire_w && !freeze_g) inst_q <= inst_q + CNT_WIDTH'(1);
      if (stall_g || freeze_g)       stall_q <= stall_q + CNT_WIDTH'(1);
    end
  end

  assign bus.cycle_cnt = cycle_q;
  assign bus.inst_cnt  = inst_q;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (FLUSH_CYCLES=2/32-bit counters and
// FLUSH_CYCLES=3/4-bit counters) checked every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst;
  logic [31:0] inst_d, inst_x;
  logic redirect_x, mem_busy, retire_w, cnt_clr;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl_if #(.CNT_WIDTH(32)) bus1 ();
  pipeline_hazard_ctrl_if #(.CNT_WIDTH(4))  bus2 ();

  assign bus1.inst_d = inst_d;     assign bus2.inst_d = inst_d;
  assign bus1.inst_x = inst_x;     assign bus2.inst_x = inst_x;
  assign bus1.redirect_x = redirect_x; assign bus2.redirect_x = redirect_x;
  assign bus1.mem_busy = mem_busy; assign bus2.mem_busy = mem_busy;
  assign bus1.retire_w = retire_w; assign bus2.retire_w = retire_w;
  assign bus1.cnt_clr = cnt_clr;   assign bus2.cnt_clr = cnt_clr;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_WIDTH(32)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_WIDTH(4))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: flush cycles still owed and counters, per instance
  int     fc[2]    = '{2, 3};
  longint mask[2]  = '{64'hFFFF_FFFF, 64'hF};
  int     owed[2]  = '{0, 0};
  longint m_cyc[2] = '{0, 0};
  longint m_ins[2] = '{0, 0};
  longint m_stl[2] = '{0, 0};
  logic [4:0] hz[2];

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] LW_X5  = 32'h0000_A283; // lw x5,0(x1)
  localparam logic [31:0] ADD_65 = 32'h0022_8333; // add x6,x5,x2
  localparam logic [31:0] LUI_X5 = 32'h0000_12B7; // lui x5,1
  localparam logic [31:0] LW_X0  = 32'h0000_A003; // lw x0,0(x1)

  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
  endfunction

  // True when X is a load whose nonzero destination is a source D really reads
  function automatic logic dep_on_load();
    logic [4:0] rd;
    rd = inst_x[11:7];
    if (inst_x[6:0] != 7'b0000011 || rd == 5'd0) return 1'b0;
    return (uses_rs1(inst_d[6:0]) && inst_d[19:15] == rd) ||
           (uses_rs2(inst_d[6:0]) && inst_d[24:20] == rd);
  endfunction

  // Expected {stall_f, stall_d, bubble_x, flush_d, freeze} for this cycle
  function automatic logic [4:0] exp_haz(input int owed_n);
    if (rst)          return 5'b00000;
    if (mem_busy)     return 5'b00001;
    if (owed_n > 0)   return 5'b00010;
    if (redirect_x)   return 5'b00010;
    if (dep_on_load()) return 5'b11100;
    return 5'b00000;
  endfunction

  function automatic int next_owed(input int owed_n, input int fcn);
    if (rst)        return 0;
    if (mem_busy)   return owed_n;
    if (owed_n > 0) return owed_n - 1;
    if (redirect_x) return fcn - 1;
    return 0;
  endfunction

  function automatic logic [4:0] obs_haz(input int d);
    if (d == 0) return {bus1.stall_f, bus1.stall_d, bus1.bubble_x, bus1.flush_d, bus1.freeze};
    return {bus2.stall_f, bus2.stall_d, bus2.bubble_x, bus2.flush_d, bus2.freeze};
  endfunction

  function automatic logic [63:0] obs_cnt(input int d, input int k);
    if (d == 0) return (k == 0) ? {32'b0, bus1.cycle_cnt} : (k == 1) ? {32'b0, bus1.inst_cnt} : {32'b0, bus1.stall_cnt};
    return (k == 0) ? {60'b0, bus2.cycle_cnt} : (k == 1) ? {60'b0, bus2.inst_cnt} : {60'b0, bus2.stall_cnt};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: compare against the model, take the edge, advance the model
  task automatic step(input string tag);
    #1;
    for (int d = 0; d < 2; d++) begin
      hz[d] = exp_haz(owed[d]);
      chk($sformatf("%s.haz%0d", tag, d), 64'(obs_haz(d)), 64'(hz[d]));
      chk($sformatf("%s.cyc%0d", tag, d), obs_cnt(d, 0), 64'(m_cyc[d]));
      chk($sformatf("%s.ins%0d", tag, d), obs_cnt(d, 1), 64'(m_ins[d]));
      chk($sformatf("%s.stl%0d", tag, d), obs_cnt(d, 2), 64'(m_stl[d]));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst || cnt_clr) begin
        m_cyc[d] = 0; m_ins[d] = 0; m_stl[d] = 0;
      end else begin
        m_cyc[d] = (m_cyc[d] + 1) & mask[d];
        if (retire_w && !hz[d][0])    m_ins[d] = (m_ins[d] + 1) & mask[d];
        if (hz[d][4] || hz[d][0])     m_stl[d] = (m_stl[d] + 1) & mask[d];
      end
      owed[d] = next_owed(owed[d], fc[d]);
    end
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops[11];
    logic [6:0] op;
    logic [4:0] rd, r1, r2;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
            7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011, 7'b1111111};
    op = ops[$urandom_range(0, 10)];
    rd = 5'($urandom_range(0, 5));
    r1 = 5'($urandom_range(0, 5));
    r2 = 5'($urandom_range(0, 5));
    return {7'b0, r2, r1, 3'b010, rd, op};
  endfunction

  initial begin
    rst = 1'b1; inst_d = NOP; inst_x = NOP;
    redirect_x = 1'b0; mem_busy = 1'b0; retire_w = 1'b0; cnt_clr = 1'b0;
    step("reset0");
    step("reset1");
    #1; chk("reset_cycle_cnt", 64'(bus1.cycle_cnt), 64'd0);
    chk("reset_freeze", 64'(bus1.freeze), 64'd0);
    rst = 1'b0;

    // Load-use and its non-hazard variants
    inst_x = LW_X5; inst_d = ADD_65;
    #1; chk("lu_stall_f", 64'(bus1.stall_f), 64'd1); chk("lu_bubble", 64'(bus1.bubble_x), 64'd1);
    step("lu");
    inst_x = NOP; step("lu_after");
    inst_x = LW_X5; inst_d = LUI_X5;
    #1; chk("lui_nostall", 64'(bus1.stall_f), 64'd0);
    step("lui");
    inst_x = LW_X0; inst_d = ADD_65;
    #1; chk("x0_nostall", 64'(bus1.stall_f), 64'd0);
    step("lwx0");
    inst_x = NOP; inst_d = NOP;
    for (int i = 0; i < 4; i++) step("idle");

    // Redirect, with a load-use in the squash window
    redirect_x = 1'b1; step("redir_t0");
    redirect_x = 1'b0; inst_x = LW_X5; inst_d = ADD_65;
    #1; chk("redir_t1_flush", 64'(bus1.flush_d), 64'd1); chk("redir_t1_nostall", 64'(bus1.stall_f), 64'd0);
    step("redir_t1");
    inst_x = NOP; inst_d = NOP;
    #1; chk("redir_t2_flush", 64'(bus1.flush_d), 64'd0);
    step("redir_t2");
    for (int i = 0; i < 3; i++) step("idle");

    // Freeze mid-flush
    redirect_x = 1'b1; step("fz_t0");
    redirect_x = 1'b0; mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; chk("fz_freeze", 64'(bus1.freeze), 64'd1); chk("fz_noflush", 64'(bus1.flush_d), 64'd0);
      step("fz_busy");
    end
    mem_busy = 1'b0;
    #1; chk("fz_resume_flush", 64'(bus1.flush_d), 64'd1);
    step("fz_resume");
    #1; chk("fz_done", 64'(bus1.flush_d), 64'd0);
    for (int i = 0; i < 4; i++) step("idle");

    // Everything at once: only freeze
    mem_busy = 1'b1; redirect_x = 1'b1; inst_x = LW_X5; inst_d = ADD_65;
    #1; chk("all_freeze", 64'(bus1.freeze), 64'd1);
    chk("all_only", 64'(obs_haz(0)), 64'(5'b00001));
    step("all");
    mem_busy = 1'b0; redirect_x = 1'b0; inst_x = NOP; inst_d = NOP;
    for (int i = 0; i < 4; i++) step("idle");

    // Counters: 100 cycles from reset, 60 retiring
    rst = 1'b1; step("cnt_rst"); rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      retire_w = (i < 60); step("cnt_run");
    end
    #1; chk("cnt_cycle100", 64'(bus1.cycle_cnt), 64'd100); chk("cnt_inst60", 64'(bus1.inst_cnt), 64'd60);
    retire_w = 1'b1; cnt_clr = 1'b1; step("cnt_clr");
    cnt_clr = 1'b0; retire_w = 1'b0;
    #1; chk("clr_cycle", 64'(bus1.cycle_cnt), 64'd0); chk("clr_inst", 64'(bus1.inst_cnt), 64'd0);
    for (int i = 0; i < 15; i++) step("wrap_run");
    #1; chk("wrap_max", 64'(bus2.cycle_cnt), 64'd15);
    step("wrap_edge");
    chk("wrap_zero", 64'(bus2.cycle_cnt), 64'd0);

    // Reset in the middle of a freeze
    mem_busy = 1'b1; step("rmw_busy");
    rst = 1'b1;
    #1; chk("rmw_rst_freeze", 64'(bus1.freeze), 64'd0);
    step("rmw_rst");
    rst = 1'b0; mem_busy = 1'b0;
    #1; chk("rmw_after_freeze", 64'(bus1.freeze), 64'd0); chk("rmw_after_flush", 64'(bus1.flush_d), 64'd0);
    step("rmw_after");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      mem_busy   = ($urandom_range(0, 4) == 0);
      redirect_x = ($urandom_range(0, 9) == 0);
      retire_w   = $urandom_range(0, 1) == 1;
      cnt_clr    = ($urandom_range(0, 49) == 0);
      inst_d     = rand_inst();
      inst_x     = ($urandom_range(0, 2) == 0) ? {20'h0, 5'($urandom_range(0, 5)), 7'b0000011} : rand_inst();
      step("rand");
      #1;
      chk("rand_stall_eq", 64'(bus1.stall_f), 64'(bus1.stall_d));
      chk("rand_bub_flush", 64'(bus2.bubble_x & bus2.flush_d), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 3-stage RISC-V core (F, D/X, W). It detects load-use hazards between D and X, sequences the multi-cycle wrong-path squash after a taken branch/jump, and freezes the whole pipeline while data memory or MMIO reports busy. It also keeps the cycle, retired-instruction and stall counters read through MMIO. It sits beside the forwarding-select logic and drives the stage-register enables and NOP-injection muxes.

## Interface
- FLUSH_CYCLES, 2: cycles the instruction in D is squashed after a redirect (≥1).
- CNT_WIDTH, 32: width of each performance counter.
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- inst_d  in  32  instruction currently in D.
- inst_x  in  32  instruction currently in X.
- redirect_x  in  1  taken branch or jump resolved in X this cycle.
- mem_busy  in  1  data memory/MMIO cannot complete this cycle.
- retire_w  in  1  W holds a valid, non-bubble instruction.
- cnt_clr  in  1  synchronous clear of all counters (MMIO write).
- stall_f  out  1  hold PC/F register.
- stall_d  out  1  hold D register.
- bubble_x  out  1  load NOP into X next edge.
- flush_d  out  1  replace D contents with NOP next edge.
- freeze  out  1  hold every pipeline register, including W.
- cycle_cnt  out  CNT_WIDTH  cycles since reset/clear.
- inst_cnt  out  CNT_WIDTH  retired instructions.
- stall_cnt  out  CNT_WIDTH  cycles with stall_f or freeze high.

## Operation
- Opcodes are decoded with the shared opcode macros. D reads rs1 for every opcode except LUI, AUIPC and JAL. D reads rs2 only for R-type, STORE and BRANCH.
- Load-use hazard: opcode_x == LOAD, rd_x != 0, and rd_x equals a register D actually reads.
- FSM states are RUN, FLUSH and MEM_WAIT. A down-counter flush_left (width clog2(FLUSH_CYCLES+1)) tracks the squash.
- Event priority within a cycle: mem_busy, then redirect_x, then load-use.
- RUN:
  - If mem_busy: freeze=1 and all other outputs 0. Next state is MEM_WAIT, with return target RUN.
  - Else if redirect_x: flush_d=1. If FLUSH_CYCLES>1, go to FLUSH with flush_left=FLUSH_CYCLES-1.
  - Else if load-use: stall_f=stall_d=bubble_x=1 for this one cycle only. The FSM stays in RUN because the dependency resolves through W forwarding.
- FLUSH:
  - flush_d=1 and load-use detection is suppressed.
  - Each non-frozen cycle decrements flush_left. When it reaches 1, the next state is RUN.
  - If mem_busy: freeze=1, flush_d=0, flush_left holds, and the state goes to MEM_WAIT with return target FLUSH.
- MEM_WAIT:
  - freeze=1 and all other hazard outputs 0 while mem_busy stays high.
  - The first cycle with mem_busy low evaluates exactly as the return state.
  - A redirect_x held in X during the freeze is acted on once, after the freeze ends.
- Counters:
  - cycle_cnt increments every cycle out of reset.
  - inst_cnt increments when retire_w=1 and freeze=0.
  - stall_cnt increments when stall_f or freeze is high.
  - All three wrap modulo 2^CNT_WIDTH. cnt_clr forces 0 on the next edge and has priority over increments.

## Timing
- Reset (rst high at an edge): state=RUN, flush_left=0, all counters 0. While rst is high, stall_f, stall_d, bubble_x, flush_d and freeze are 0.
- Hazard outputs are combinational from the registered state and the current inputs, so they respond in the same cycle as the event. Zero-latency response is required for correct enables.
- Counters are registered and update at the edge following the qualifying cycle.
- Redirect at cycle t, no freeze: flush_d is high for cycles t through t+FLUSH_CYCLES-1, then returns to RUN.
- Reset asserted in the middle of FLUSH or MEM_WAIT aborts it immediately, with no residual flush.
- freeze, stall_f and flush_d may all be needed in the same cycle. Priority resolves this, and freeze wins.
- stall_f and stall_d are always equal.
- bubble_x is never asserted together with flush_d.

## Test plan
- Load-use: inst_x=lw x5,0(x1), inst_d=add x6,x5,x2 → stall_f=stall_d=bubble_x=1 for one cycle. The same pair with inst_d=lui x5,1 gives no stall, and lw x0 gives no stall.
- Redirect, FLUSH_CYCLES=2: redirect_x pulse at cycle 10 → flush_d high in cycles 10 and 11, low in cycle 12. A load-use pattern in cycle 11 is ignored.
- Freeze mid-flush: redirect at 10, mem_busy in cycles 11–13 → freeze high 11–13, flush_d high at 10 and 14 only.
- Simultaneous events: mem_busy, redirect_x and load-use all true in one cycle → only freeze=1. stall_cnt increments by 1.
- Counters: 100 cycles with retire_w on 60 of them, no freeze → cycle_cnt=100, inst_cnt=60. Then cnt_clr=1 together with retire_w=1 → all counters 0 next cycle. Preloading to 2^32-1 and advancing one cycle → wraps to 0.
- Reset mid-MEM_WAIT: rst during freeze → all hazard outputs 0 and state RUN. After release with mem_busy=0, no freeze and no flush.
